sonar_echo_emulator: RTL

SONAR_ECHO_EMULATOR -- requirements
Module: sonar_echo_emulator

---
 rtl/sonar_echo_emulator.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sonar_echo_emulator.sv
// Ultrasonic ranger emulator: accepts a trigger pulse of sufficient width and answers,
// after a fixed burst delay, with an echo whose width encodes the emulated range.
module sonar_echo_emulator #(
    parameter int MIN_TRIG_CYC = 500,
    parameter int BURST_CYC    = 10000,
    parameter int CYC_PER_MM   = 292,
    parameter int MIN_MM       = 20,
    parameter int MAX_MM       = 4000,
    parameter int TIMEOUT_CYC  = 1900000,
    parameter int HOLDOFF_CYC  = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trig,
    input  logic [11:0] distance_mm,
    input  logic        object_present,
    output logic        echo,
    output logic        busy,
    output logic        trig_err
);

    typedef enum logic [2:0] {IDLE, TRIG_HIGH, BURST, ECHO, HOLDOFF} state_t;

    localparam logic [20:0] MIN_TRIG_L   = 21'(MIN_TRIG_CYC);
    localparam logic [20:0] BURST_LAST   = 21'(BURST_CYC - 1);
    localparam logic [20:0] TIMEOUT_L    = 21'(TIMEOUT_CYC);
    localparam logic [20:0] HOLDOFF_LAST = 21'(HOLDOFF_CYC - 1);
    localparam logic [20:0] CYC_PER_MM_L = 21'(CYC_PER_MM);
    localparam logic [11:0] MIN_MM_L     = 12'(MIN_MM);
    localparam logic [11:0] MAX_MM_L     = 12'(MAX_MM);

    state_t      state, state_next;
    logic [20:0] cnt, cnt_next;
    logic        trig_meta, trig_s, trig_d;
    logic [1:0]  primed;
    logic        armed;
    logic        trig_rise;
    logic [11:0] lat_dist;
    logic        lat_obj;
    logic        lat_en;
    logic        echo_next, trig_err_next;
    logic [11:0] eff_mm;
    logic [20:0] echo_width;

    assign trig_rise = trig_s & ~trig_d;
    assign busy      = (state != IDLE);

    always_comb begin
        eff_mm = (lat_dist < MIN_MM_L) ? MIN_MM_L : lat_dist;
        if (!lat_obj || (lat_dist > MAX_MM_L))
            echo_width = TIMEOUT_L;
        else
            echo_width = {9'd0, eff_mm} * CYC_PER_MM_L;
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        echo_next     = 1'b0;
        trig_err_next = 1'b0;
        lat_en        = 1'b0;
        case (state)
            IDLE: begin
                if (trig_rise && armed) begin
                    state_next = TRIG_HIGH;
                    cnt_next   = 21'd1;
                end
            end
            TRIG_HIGH: begin
                if (trig_s) begin
                    if (cnt < MIN_TRIG_L)
                        cnt_next = cnt + 21'd1;
                end else if (cnt >= MIN_TRIG_L) begin
                    lat_en     = 1'b1;
                    state_next = BURST;
                    cnt_next   = '0;
                end else begin
                    trig_err_next = 1'b1;
                    state_next    = IDLE;
                    cnt_next      = '0;
                end
            end
            BURST: begin
                if (cnt == BURST_LAST) begin
                    state_next = ECHO;
                    cnt_next   = echo_width - 21'd1;
                    echo_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 21'd1;
                end
            end
            ECHO: begin
                if (cnt == '0) begin
                    if (HOLDOFF_CYC == 0) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        state_next = HOLDOFF;
                        cnt_next   = HOLDOFF_LAST;
                    end
                end else begin
                    cnt_next  = cnt - 21'd1;
                    echo_next = 1'b1;
                end
            end
            HOLDOFF: begin
                if (cnt == '0)
                    state_next = IDLE;
                else
                    cnt_next = cnt - 21'd1;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // armed only rises once the synchronizer carries a real low sample, so a trigger
    // held high through reset release cannot masquerade as a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_meta <= 1'b0;
            trig_s    <= 1'b0;
            trig_d    <= 1'b0;
            primed    <= 2'b00;
            armed     <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            lat_dist  <= '0;
            lat_obj   <= 1'b0;
            echo      <= 1'b0;
            trig_err  <= 1'b0;
        end else begin
            trig_meta <= trig;
            trig_s    <= trig_meta;
            trig_d    <= trig_s;
            primed    <= {primed[0], 1'b1};
            if (primed[1] && !trig_s)
                armed <= 1'b1;
            state     <= state_next;
            cnt       <= cnt_next;
            echo      <= echo_next;
            trig_err  <= trig_err_next;
            if (lat_en) begin
                lat_dist <= distance_mm;
                lat_obj  <= object_present;
            end
        end
    end

endmodule
